// File: rtl/search_request_queue.sv
// search_request_queue: tagged request FIFO in front of the binary search engine.
// Issues one key at a time, waits for a match/no-match pulse or a timeout, and
// returns the tagged result over a ready/valid channel.
module search_request_queue #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic [DATA_WIDTH-1:0]           req_key,
    input  logic [TAG_WIDTH-1:0]            req_tag,
    input  logic                            req_valid,
    output logic                            req_ready,
    output logic [DATA_WIDTH-1:0]           search_key,
    output logic                            search_key_valid,
    input  logic [$clog2(DEPTH)-1:0]        search_response_index,
    input  logic                            search_response_valid,
    input  logic                            search_no_match,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    output logic [$clog2(DEPTH)-1:0]        rsp_index,
    output logic                            rsp_found,
    output logic                            rsp_timeout,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            err_stray
);
    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWait, StReport} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] key_mem [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_d;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [ToW-1:0]        to_cnt_q;
    logic                  push;
    logic                  pop;
    logic                  engine_pulse;

    // Ready depends only on the registered count, never on req_valid.
    assign req_ready    = (fifo_count != CntW'(FIFO_DEPTH));
    assign push         = req_valid && req_ready;
    assign pop          = (state_q == StIdle) && (fifo_count != '0);
    assign engine_pulse = search_response_valid || search_no_match;

    // Request storage; no reset needed because the count gates every read.
    always_ff @(posedge Clk) begin
        if (push) begin
            key_mem[wr_ptr_q] <= req_key;
            tag_mem[wr_ptr_q] <= req_tag;
        end
    end

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_d = fifo_count;
        if (push && !pop) begin
            count_d = fifo_count + CntW'(1);
        end else if (pop && !push) begin
            count_d = fifo_count - CntW'(1);
        end
    end

    // Circular pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            fifo_count <= count_d;
        end
    end

    // Issue/wait/report sequencer with registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q          <= StIdle;
            search_key       <= '0;
            search_key_valid <= 1'b0;
            tag_q            <= '0;
            to_cnt_q         <= '0;
            rsp_tag          <= '0;
            rsp_index        <= '0;
            rsp_found        <= 1'b0;
            rsp_timeout      <= 1'b0;
            rsp_valid        <= 1'b0;
            err_stray        <= 1'b0;
        end else begin
            search_key_valid <= 1'b0;
            // Engine pulses are only meaningful while a search is outstanding.
            if ((state_q != StWait) && engine_pulse) begin
                err_stray <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        search_key       <= key_mem[rd_ptr_q];
                        tag_q            <= tag_mem[rd_ptr_q];
                        search_key_valid <= 1'b1;
                        to_cnt_q         <= '0;
                        state_q          <= StWait;
                    end
                end
                StWait: begin
                    to_cnt_q <= to_cnt_q + ToW'(1);
                    if (search_response_valid) begin
                        rsp_tag     <= tag_q;
                        rsp_index   <= search_response_index;
                        rsp_found   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_q     <= StReport;
                    end else if (search_no_match) begin
                        rsp_tag     <= tag_q;
                        rsp_index   <= {IdxW{1'b0}};
                        rsp_found   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_q     <= StReport;
                    end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
                        rsp_tag     <= tag_q;
                        rsp_index   <= {IdxW{1'b0}};
                        rsp_found   <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state_q     <= StReport;
                    end
                end
                StReport: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
